// File: rtl/prescaled_updown_counter.sv
// ---------------------------------------------------------------------------
// prescaled_updown_counter : prescaled up/down/centre timer with compare/PWM
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module prescaled_updown_counter #(
  parameter int BITWIDTH           = 8,
  parameter int PRESCALER_BITWIDTH = 4,
  parameter int START_RESTARTS     = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic [1:0]                    mode,
  input  logic                          autoreload,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler,
  input  logic [BITWIDTH-1:0]           reload_value,
  input  logic [BITWIDTH-1:0]           compare_value,
  output logic                          counting,
  output logic [BITWIDTH-1:0]           value,
  output logic                          direction,
  output logic                          overflow,
  output logic                          compare_match,
  output logic                          pwm
);

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_CENTRE = 2'd2;

  localparam logic [BITWIDTH-1:0]           ONE  = BITWIDTH'(1);
  localparam logic [PRESCALER_BITWIDTH-1:0] PONE = PRESCALER_BITWIDTH'(1);

  logic [PRESCALER_BITWIDTH-1:0] prescale_count;
  logic [1:0]                    mode_latched;
  logic                          tick;
  logic                          do_stop;
  logic                          do_load;
  logic [BITWIDTH-1:0]           load_value;
  logic [BITWIDTH-1:0]           next_value;
  logic                          next_direction;
  logic                          period_end;

  always_comb begin
    do_stop        = counting && stop;
    do_load        = start && !stop && (!counting || (START_RESTARTS != 0));
    tick           = counting && (prescale_count == prescaler);
    load_value     = (mode == MODE_DOWN) ? reload_value : '0;
    next_value     = value;
    next_direction = direction;
    period_end     = 1'b0;
    case (mode_latched)
      MODE_DOWN: begin
        if (value == '0) begin
          next_value = reload_value;
          period_end = 1'b1;
        end else begin
          next_value = value - ONE;
        end
      end
      MODE_CENTRE: begin
        // An up phase that finds value already at/above reload turns round at once
        if (!direction && (value < reload_value)) begin
          next_value = value + ONE;
          if (next_value >= reload_value) next_direction = 1'b1;
        end else if (value == '0) begin
          next_value     = '0;
          next_direction = 1'b0;
          period_end     = 1'b1;
        end else begin
          next_value     = value - ONE;
          next_direction = 1'b1;
          if (next_value == '0) begin
            next_direction = 1'b0;
            period_end     = 1'b1;
          end
        end
      end
      default: begin
        if (value >= reload_value) begin
          next_value = '0;
          period_end = 1'b1;
        end else begin
          next_value = value + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      counting       <= 1'b0;
      value          <= '0;
      direction      <= 1'b0;
      overflow       <= 1'b0;
      compare_match  <= 1'b0;
      pwm            <= 1'b0;
      prescale_count <= '0;
      mode_latched   <= MODE_UP;
    end else begin
      overflow      <= 1'b0;
      compare_match <= 1'b0;
      pwm           <= counting && (value < compare_value);
      if (do_stop) begin
        counting <= 1'b0;
      end else if (do_load) begin
        counting       <= 1'b1;
        mode_latched   <= mode;
        prescale_count <= '0;
        value          <= load_value;
        direction      <= (mode == MODE_DOWN);
        compare_match  <= (load_value == compare_value);
      end else if (tick) begin
        prescale_count <= '0;
        value          <= next_value;
        direction      <= next_direction;
        overflow       <= period_end;
        compare_match  <= (next_value == compare_value);
        if (period_end && !autoreload) counting <= 1'b0;
      end else if (counting) begin
        prescale_count <= prescale_count + PONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prescaled_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_prescaled_updown_counter : directed scenarios plus randomized model check
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prescaled_updown_counter;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       autoreload;
  logic [3:0] prescaler;
  logic [7:0] reload_value;
  logic [7:0] compare_value;

  logic       counting, direction, overflow, compare_match, pwm;
  logic [7:0] value;
  logic       r_counting, r_direction, r_overflow, r_compare_match, r_pwm;
  logic [7:0] r_value;

  int total = 0;
  int bad   = 0;

  // Reference model state, plain integers
  int m_run, m_val, m_dir, m_pcnt, m_mode, m_pos, m_ov, m_cm, m_pwm;

  prescaled_updown_counter #(.BITWIDTH(8), .PRESCALER_BITWIDTH(4), .START_RESTARTS(0)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .autoreload(autoreload), .prescaler(prescaler), .reload_value(reload_value),
    .compare_value(compare_value), .counting(counting), .value(value),
    .direction(direction), .overflow(overflow), .compare_match(compare_match), .pwm(pwm)
  );

  prescaled_updown_counter #(.BITWIDTH(8), .PRESCALER_BITWIDTH(4), .START_RESTARTS(1)) dut_r (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .autoreload(autoreload), .prescaler(prescaler), .reload_value(reload_value),
    .compare_value(compare_value), .counting(r_counting), .value(r_value),
    .direction(r_direction), .overflow(r_overflow), .compare_match(r_compare_match), .pwm(r_pwm)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Position-based model: up wraps modulo R+1, centre walks a 2R-long triangle.
  task automatic model_step();
    int r;
    r = int'(reload_value);
    if (!reset) begin
      m_run = 0; m_val = 0; m_dir = 0; m_pcnt = 0; m_mode = 0;
      m_pos = 0; m_ov = 0; m_cm = 0; m_pwm = 0;
      return;
    end
    m_pwm = (m_run != 0 && m_val < int'(compare_value)) ? 1 : 0;
    m_ov  = 0;
    m_cm  = 0;
    if (m_run != 0 && stop) begin
      m_run = 0;
    end else if (start && !stop && m_run == 0) begin
      m_run  = 1;
      m_mode = int'(mode);
      m_pcnt = 0;
      m_pos  = 0;
      m_val  = (m_mode == 1) ? r : 0;
      m_dir  = (m_mode == 1) ? 1 : 0;
      m_cm   = (m_val == int'(compare_value)) ? 1 : 0;
    end else if (m_run != 0) begin
      if (m_pcnt == int'(prescaler)) begin
        m_pcnt = 0;
        if (m_mode == 1) begin
          if (m_val == 0) begin m_val = r; m_ov = 1; end
          else m_val = m_val - 1;
        end else if (m_mode == 2) begin
          if (r == 0) m_ov = 1;
          else begin
            m_pos = (m_pos + 1) % (2 * r);
            m_val = (m_pos <= r) ? m_pos : 2 * r - m_pos;
            m_dir = (m_pos >= r) ? 1 : 0;
            m_ov  = (m_pos == 0) ? 1 : 0;
          end
        end else begin
          if (m_val >= r) begin m_val = 0; m_ov = 1; end
          else m_val = m_val + 1;
        end
        m_cm = (m_val == int'(compare_value)) ? 1 : 0;
        if (m_ov != 0 && !autoreload) m_run = 0;
      end else begin
        m_pcnt = (m_pcnt + 1) % 16;
      end
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    clk1();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    clk1();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; stop = 1'b0; mode = 2'd0; autoreload = 1'b1;
    prescaler = 4'd0; reload_value = 8'd5; compare_value = 8'd3;
    for (int i = 0; i < 3; i++) begin
      clk1();
      total++;
      if ({counting, value, direction, overflow, compare_match, pwm} !== 13'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got cnt=%b val=%0d dir=%b ov=%b cm=%b pwm=%b, want all 0",
                 i, counting, value, direction, overflow, compare_match, pwm);
      end
      total++;
      if ({r_counting, r_value, r_direction, r_overflow, r_compare_match, r_pwm} !== 13'd0) begin
        bad++;
        $display("FAIL reset_outputs_r cycle %0d: got cnt=%b val=%0d, want all 0", i, r_counting, r_value);
      end
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_up();
    logic [7:0] ev;
    do_reset();
    mode = 2'd0; autoreload = 1'b1; prescaler = 4'd0; reload_value = 8'd3; compare_value = 8'd0;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      ev = 8'(k % 4);
      total++;
      if ({counting, overflow, value} !== {1'b1, (k % 4 == 0 && k > 0), ev}) begin
        bad++;
        $display("FAIL up_seq k=%0d: got cnt=%b ov=%b val=%0d, want cnt=1 ov=%b val=%0d",
                 k, counting, overflow, value, (k % 4 == 0 && k > 0), ev);
      end
      clk1();
    end
  endtask

  task automatic test_down_oneshot();
    logic [7:0] ev;
    do_reset();
    mode = 2'd1; autoreload = 1'b0; prescaler = 4'd2; reload_value = 8'd2; compare_value = 8'd200;
    pulse_start();
    for (int k = 0; k < 13; k++) begin
      ev = (k < 3) ? 8'd2 : (k < 6) ? 8'd1 : (k < 9) ? 8'd0 : 8'd2;
      total++;
      if ({counting, overflow, value} !== {(k < 9), (k == 9), ev}) begin
        bad++;
        $display("FAIL down_oneshot k=%0d: got cnt=%b ov=%b val=%0d, want cnt=%b ov=%b val=%0d",
                 k, counting, overflow, value, (k < 9), (k == 9), ev);
      end
      clk1();
    end
  endtask

  task automatic test_centre();
    int p, pp, v, vprev;
    logic [11:0] exp_v;
    do_reset();
    mode = 2'd2; autoreload = 1'b1; prescaler = 4'd0; reload_value = 8'd3; compare_value = 8'd2;
    pulse_start();
    for (int k = 0; k < 14; k++) begin
      p     = k % 6;
      pp    = (k + 5) % 6;
      v     = (p <= 3) ? p : 6 - p;
      vprev = (pp <= 3) ? pp : 6 - pp;
      exp_v = {1'b1, (p >= 3), (p == 0 && k > 0), (v == 2), (k > 0 && vprev < 2), 7'(v)};
      total++;
      if ({counting, direction, overflow, compare_match, pwm, value[6:0]} !== exp_v) begin
        bad++;
        $display("FAIL centre k=%0d: got cnt=%b dir=%b ov=%b cm=%b pwm=%b val=%0d, want %b",
                 k, counting, direction, overflow, compare_match, pwm, value, exp_v);
      end
      clk1();
    end
  endtask

  task automatic test_stop_start();
    do_reset();
    mode = 2'd0; autoreload = 1'b1; prescaler = 4'd0; reload_value = 8'd10; compare_value = 8'd0;
    pulse_start();
    repeat (5) clk1();
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    repeat (3) clk1();
    total++;
    if ({counting, value} !== {1'b0, 8'd5}) begin
      bad++;
      $display("FAIL stop_hold: got cnt=%b val=%0d, want cnt=0 val=5", counting, value);
    end
    pulse_start();
    total++;
    if ({counting, value} !== {1'b1, 8'd0}) begin
      bad++;
      $display("FAIL restart_after_stop: got cnt=%b val=%0d, want cnt=1 val=0", counting, value);
    end
    repeat (2) clk1();
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    start = 1'b1; stop = 1'b1;
    clk1();
    start = 1'b0; stop = 1'b0;
    clk1();
    total++;
    if ({counting, value} !== {1'b0, 8'd2}) begin
      bad++;
      $display("FAIL start_stop_same: got cnt=%b val=%0d, want cnt=0 val=2", counting, value);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    mode = 2'd0; autoreload = 1'b1; prescaler = 4'd0; reload_value = 8'd10; compare_value = 8'd9;
    pulse_start();
    repeat (7) clk1();
    total++;
    if ({counting, value, pwm} !== {1'b1, 8'd7, 1'b1}) begin
      bad++;
      $display("FAIL midcount_pre: got cnt=%b val=%0d pwm=%b, want cnt=1 val=7 pwm=1", counting, value, pwm);
    end
    reset = 1'b0; start = 1'b1;
    repeat (2) begin
      clk1();
      total++;
      if ({counting, value, direction, overflow, compare_match, pwm} !== 13'd0) begin
        bad++;
        $display("FAIL midcount_reset: got cnt=%b val=%0d pwm=%b, want all 0", counting, value, pwm);
      end
    end
    reset = 1'b1; start = 1'b0;
    clk1();
    total++;
    if (counting !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got cnt=%b, want 0", counting);
    end
    pulse_start();
    repeat (2) clk1();
    total++;
    if ({counting, value} !== {1'b1, 8'd2}) begin
      bad++;
      $display("FAIL restart_after_reset: got cnt=%b val=%0d, want cnt=1 val=2", counting, value);
    end
  endtask

  task automatic test_restart();
    do_reset();
    mode = 2'd0; autoreload = 1'b1; prescaler = 4'd0; reload_value = 8'd9; compare_value = 8'd100;
    pulse_start();
    repeat (6) clk1();
    total++;
    if ({r_counting, r_value} !== {1'b1, 8'd6}) begin
      bad++;
      $display("FAIL restart_pre: got cnt=%b val=%0d, want cnt=1 val=6", r_counting, r_value);
    end
    pulse_start();
    total++;
    if ({r_counting, r_overflow, r_value} !== {1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL restart_reload: got cnt=%b ov=%b val=%0d, want cnt=1 ov=0 val=0",
               r_counting, r_overflow, r_value);
    end
    total++;
    if ({counting, value} !== {1'b1, 8'd7}) begin
      bad++;
      $display("FAIL no_restart_ignores_start: got cnt=%b val=%0d, want cnt=1 val=7", counting, value);
    end
    clk1();
    total++;
    if (r_value !== 8'd1) begin
      bad++;
      $display("FAIL restart_continue: got val=%0d, want 1", r_value);
    end
  endtask

  task automatic test_random();
    logic [12:0] got, exp_v;
    int rv;
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      rv            = int'($urandom_range(12));
      reload_value  = 8'(rv);
      compare_value = 8'($urandom_range(rv + 1));
      prescaler     = 4'($urandom_range(3));
      autoreload    = 1'($urandom_range(1));
      for (int c = 0; c < 150; c++) begin
        start = ($urandom_range(11) == 0);
        stop  = ($urandom_range(29) == 0);
        mode  = 2'($urandom_range(3));
        clk1();
        got   = {counting, direction, overflow, compare_match, pwm, value};
        exp_v = {m_run[0], m_dir[0], m_ov[0], m_cm[0], m_pwm[0], m_val[7:0]};
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL random seg=%0d cyc=%0d: got cnt/dir/ov/cm/pwm/val=%b, want %b", seg, c, got, exp_v);
        end
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; autoreload = 1'b0;
    prescaler = 4'd0; reload_value = 8'd0; compare_value = 8'd0;
    @(negedge clock);
    test_reset();
    test_up();
    test_down_oneshot();
    test_centre();
    test_stop_start();
    test_reset_midcount();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
